// File: rtl/lut_cfg_loader.sv
// Serial-to-parallel configuration loader for a bank of fracturable LUTs.
// Streams CFG_WIDTH-bit frames MSB-first and commits each one with a one-cycle per-LUT enable.
module lut_cfg_loader #(
  parameter int INPUTS    = 4,
  parameter int MEM_SIZE  = 2**INPUTS,
  parameter int CFG_WIDTH = 2*MEM_SIZE+1,
  parameter int NUM_LUTS  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  output logic [CFG_WIDTH-1:0] config_out,
  output logic [NUM_LUTS-1:0]  cen,
  output logic                 busy,
  output logic                 done
);

  localparam int CntW = $clog2(CFG_WIDTH);
  localparam int IdxW = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(CFG_WIDTH-1);
  localparam logic [IdxW-1:0] LastLut = IdxW'(NUM_LUTS-1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

  state_e                 state_q;
  // Only CFG_WIDTH-1 bits are stored: the final bit of a frame goes straight into config_out.
  logic [CFG_WIDTH-2:0]   shreg_q;
  logic [CFG_WIDTH-1:0]   shreg_d;
  logic [CFG_WIDTH-1:0]   config_q;
  logic [CntW-1:0]        bit_cnt_q;
  logic [IdxW-1:0]        lut_idx_q;
  logic [NUM_LUTS-1:0]    cen_q;
  logic                   busy_q;
  logic                   done_q;

  assign shreg_d    = {shreg_q, bit_in};
  assign bit_ready  = (state_q == SHIFT);
  assign config_out = config_q;
  assign cen        = cen_q;
  assign busy       = busy_q;
  assign done       = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      config_q  <= '0;
      bit_cnt_q <= '0;
      lut_idx_q <= '0;
      cen_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cen_q <= '0;
          if (start && !abort) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
            lut_idx_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        SHIFT: begin
          // abort outranks both the bit transfer and the commit it could trigger
          if (abort) begin
            state_q <= IDLE;
            cen_q   <= '0;
            busy_q  <= 1'b0;
          end else if (bit_valid) begin
            shreg_q <= shreg_d[CFG_WIDTH-2:0];
            if (bit_cnt_q == LastBit) begin
              config_q <= shreg_d;
              cen_q    <= NUM_LUTS'(1) << lut_idx_q;
              state_q  <= COMMIT;
            end else begin
              bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
          end
        end
        COMMIT: begin
          cen_q <= '0;
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (lut_idx_q == LastLut) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            lut_idx_q <= lut_idx_q + IdxW'(1);
            bit_cnt_q <= '0;
            state_q   <= SHIFT;
          end
        end
        default: begin
          state_q <= IDLE;
          cen_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lut_cfg_loader.md
Name: lut_cfg_loader

Overview:
- Serial configuration loader for a bank of fracturable LUTs.
- Accepts a MSB-first configuration bitstream over a valid/ready handshake and assembles one full LUT frame at a time, including the fracture (split) bit.
- Presents each frame on a shared parallel config bus and pulses the matching per-LUT config enable for exactly one cycle.
- Sits between the bitstream source (scan/JTAG front end) and the config_in/cen pins of the LUT bank.

Parameters:
INPUTS, 4, inputs per LUT half.
MEM_SIZE, 2**INPUTS, truth-table bits per LUT half.
CFG_WIDTH, 2*MEM_SIZE+1, frame width in bits; MSB is the fracture bit.
NUM_LUTS, 4, LUTs loaded per start, in index order 0..NUM_LUTS-1.

Ports:
clk  in  1  single clock; drives the loader and the LUT config clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse that begins a load of all NUM_LUTS frames.
abort  in  1  synchronous cancel of a load in progress.
bit_in  in  1  serial config data.
bit_valid  in  1  bit_in is valid this cycle.
bit_ready  out  1  loader accepts a bit this cycle.
config_out  out  CFG_WIDTH  parallel frame to the shared config_in bus.
cen  out  NUM_LUTS  one-hot per-LUT config enable.
busy  out  1  load in progress.
done  out  1  sticky flag: the last load completed.

Behaviour:
- Reset (async, rst_n=0): state IDLE; config_out=0, cen=0, bit_ready=0, busy=0, done=0; shift register, bit_cnt and lut_idx all 0.
- States: IDLE, SHIFT, COMMIT.
- IDLE: bit_ready=0, busy=0.
  - start=1: go to SHIFT; clear bit_cnt and lut_idx; done<=0; busy=1 from the next cycle.
- SHIFT: bit_ready=1, combinational from state.
  - A bit transfers only when bit_valid & bit_ready.
  - On transfer: shreg <= {shreg[CFG_WIDTH-2:0], bit_in}; bit_cnt++. The first bit of a frame ends in the MSB (fracture bit).
  - bit_valid while bit_ready=0 is ignored and the bit is not consumed.
  - Transfer with bit_cnt==CFG_WIDTH-1: register config_out <= final shifted value and cen <= onehot(lut_idx), then go to COMMIT.
- COMMIT: lasts exactly one cycle.
  - cen is one-hot and config_out is stable; bit_ready=0.
  - Next cycle cen<=0.
  - If lut_idx==NUM_LUTS-1: go to IDLE, done<=1, busy<=0.
  - Otherwise: lut_idx++, bit_cnt<=0, go to SHIFT.
- config_out holds its last committed frame until the next commit. It never shows partial shift contents.
- Latency: cen rises 1 cycle after the last bit of a frame is accepted. done rises 1 cycle after the final COMMIT.
- Minimum load time: NUM_LUTS*(CFG_WIDTH+1) cycles after start, plus 1.
- start while busy: ignored.
- abort=1 in SHIFT or COMMIT:
  - next state IDLE, cen<=0 (any pending cen is suppressed), busy<=0, done stays 0, config_out unchanged.
  - abort has priority over bit transfer and over commit in the same cycle.
- abort in IDLE: no effect. abort and start in the same IDLE cycle: abort wins, remain IDLE.
- Reset mid-operation: immediate return to reset values. Any cen in flight is dropped.
- Counters: bit_cnt width clog2(CFG_WIDTH); lut_idx width clog2(NUM_LUTS), minimum 1. No wrap beyond the stated terminal values.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately, bit_ready=0, state IDLE.
- Single frame (NUM_LUTS=1, CFG_WIDTH=33): start, then stream 33'h1_DEAD_BEEF MSB-first with bit_valid held high -> cen=1'b1 for exactly 1 cycle, one cycle after the 33rd bit, with config_out=33'h1DEADBEEF; done=1 the next cycle; busy=0.
- Four frames, default params: frames 33'h0_0000_FFFF, 33'h1_AAAA_5555, 33'h0_1234_5678, 33'h1_FFFF_0000 -> cen pulses 0001, 0010, 0100, 1000 in order with matching config_out; bit_ready=0 during each COMMIT; done=1 after the 4th pulse.
- Back-pressure/gaps: randomly deassert bit_valid for 0-5 cycles between bits -> identical config_out values; no extra or missing bits; cen timing is relative to the last accepted bit.
- start pulsed again during frame 2 -> ignored; sequence completes normally with 4 cen pulses.
- abort at bit 17 of frame 1 -> IDLE next cycle, no cen for LUT 1, config_out still equals frame 0, done=0. A following start reloads from LUT 0.
